// File: rtl/lumber_field_p.sv
// Lumber-collection cellular automaton over a W x H grid with raster cell loading,
// a programmable generation count and an on-chip tree/lumberyard resource count.
//
// state | meaning
// IDLE  | accepts load beats and start
// RUN   | one generation per cycle until gen_count == gens
// COUNT | grid frozen, one row per cycle accumulated into the counts
// DONE  | resource registered, done pulse issued on the way back to IDLE
module lumber_field_p #(
  parameter int W     = 50,
  parameter int H     = 50,
  parameter int GEN_W = 32,
  parameter int CNT_W = $clog2(W*H+1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_valid,
  input  logic [1:0]         load_cell,
  output logic               load_ready,
  input  logic               start,
  input  logic [GEN_W-1:0]   gens,
  output logic               busy,
  output logic               done,
  output logic [GEN_W-1:0]   gen_count,
  output logic [W*H-1:0]     trees,
  output logic [W*H-1:0]     lumberyards,
  output logic [CNT_W-1:0]   tree_count,
  output logic [CNT_W-1:0]   yard_count,
  output logic [2*CNT_W-1:0] resource
);

  localparam int N     = W * H;
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;
  localparam int ROW_W = (H > 1) ? $clog2(H) : 1;
  localparam int RES_W = 2 * CNT_W;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_COUNT, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [N-1:0]       trees_q, trees_d;
  logic [N-1:0]       yards_q, yards_d;
  logic [PTR_W-1:0]   load_ptr_q, load_ptr_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [GEN_W-1:0]   gens_q, gens_d;
  logic [GEN_W-1:0]   gen_count_q, gen_count_d;
  logic [CNT_W-1:0]   tree_count_q, tree_count_d;
  logic [CNT_W-1:0]   yard_count_q, yard_count_d;
  logic [RES_W-1:0]   resource_q, resource_d;
  logic               done_q, done_d;

  logic [N-1:0]       trees_nxt, yards_nxt;
  logic [PTR_W-1:0]   row_base;
  logic [W-1:0]       row_trees, row_yards;

  // Neighbourhood per cell; positions off the grid are tied to open.
  for (genvar gr = 0; gr < H; gr++) begin : g_row
    for (genvar gc = 0; gc < W; gc++) begin : g_col
      localparam int I = gr * W + gc;
      logic [7:0] nb_t, nb_y;
      for (genvar k = 0; k < 9; k++) begin : g_nb
        if (k != 4) begin : g_ring
          localparam int NR = gr + (k / 3) - 1;
          localparam int NC = gc + (k % 3) - 1;
          localparam int J  = (k < 4) ? k : k - 1;
          if (NR >= 0 && NR < H && NC >= 0 && NC < W) begin : g_in
            assign nb_t[J] = trees_q[NR * W + NC];
            assign nb_y[J] = yards_q[NR * W + NC];
          end else begin : g_out
            assign nb_t[J] = 1'b0;
            assign nb_y[J] = 1'b0;
          end
        end
      end
      assign trees_nxt[I] = trees_q[I] ? ($countones(nb_y) < 3)
                                       : (!yards_q[I] && $countones(nb_t) >= 3);
      assign yards_nxt[I] = trees_q[I] ? ($countones(nb_y) >= 3)
                                       : (yards_q[I] && nb_y != 8'd0 && nb_t != 8'd0);
    end
  end

  assign row_base  = PTR_W'(int'(row_q) * W);
  assign row_trees = trees_q[row_base +: W];
  assign row_yards = yards_q[row_base +: W];

  always_comb begin
    state_d      = state_q;
    trees_d      = trees_q;
    yards_d      = yards_q;
    load_ptr_d   = load_ptr_q;
    row_d        = row_q;
    gens_d       = gens_q;
    gen_count_d  = gen_count_q;
    tree_count_d = tree_count_q;
    yard_count_d = yard_count_q;
    resource_d   = resource_q;
    done_d       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          gens_d       = gens;
          gen_count_d  = '0;
          tree_count_d = '0;
          yard_count_d = '0;
          resource_d   = '0;
          load_ptr_d   = '0;
          row_d        = '0;
          state_d      = (gens == '0) ? S_COUNT : S_RUN;
        end else if (load_valid) begin
          // Code 11 falls through both compares and lands as open.
          trees_d[load_ptr_q] = (load_cell == 2'b01);
          yards_d[load_ptr_q] = (load_cell == 2'b10);
          load_ptr_d = (load_ptr_q == PTR_W'(N - 1)) ? '0 : load_ptr_q + 1'b1;
        end
      end
      S_RUN: begin
        trees_d     = trees_nxt;
        yards_d     = yards_nxt;
        gen_count_d = gen_count_q + 1'b1;
        if (gen_count_d == gens_q) begin
          state_d = S_COUNT;
          row_d   = '0;
        end
      end
      S_COUNT: begin
        tree_count_d = tree_count_q + CNT_W'($countones(row_trees));
        yard_count_d = yard_count_q + CNT_W'($countones(row_yards));
        if (row_q == ROW_W'(H - 1)) begin
          state_d = S_DONE;
        end else begin
          row_d = row_q + 1'b1;
        end
      end
      S_DONE: begin
        resource_d = RES_W'(tree_count_q) * RES_W'(yard_count_q);
        done_d     = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      trees_q      <= '0;
      yards_q      <= '0;
      load_ptr_q   <= '0;
      row_q        <= '0;
      gens_q       <= '0;
      gen_count_q  <= '0;
      tree_count_q <= '0;
      yard_count_q <= '0;
      resource_q   <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      trees_q      <= trees_d;
      yards_q      <= yards_d;
      load_ptr_q   <= load_ptr_d;
      row_q        <= row_d;
      gens_q       <= gens_d;
      gen_count_q  <= gen_count_d;
      tree_count_q <= tree_count_d;
      yard_count_q <= yard_count_d;
      resource_q   <= resource_d;
      done_q       <= done_d;
    end
  end

  assign load_ready  = (state_q == S_IDLE) && !start;
  assign busy        = (state_q == S_RUN) || (state_q == S_COUNT);
  assign done        = done_q;
  assign gen_count   = gen_count_q;
  assign trees       = trees_q;
  assign lumberyards = yards_q;
  assign tree_count  = tree_count_q;
  assign yard_count  = yard_count_q;
  assign resource    = resource_q;

endmodule

// File: doc/lumber_field_p.md
# lumber_field_p

Parametrised W×H lumber-collection cellular automaton. It is the successor to the fixed 50×50 `field` block. It adds a cell-load port, a programmable generation count with a start/done handshake, and an on-chip resource count, so a bench no longer decodes the raw grid itself. It sits between the puzzle-input loader and the result reporter. The full grid stays exported for debug.

## Interface
- W, 50, grid columns (≥1)
- H, 50, grid rows (≥1)
- GEN_W, 32, width of generation-count operands
- CNT_W, $clog2(W*H+1), width of per-type cell counts
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; asynchronous, active-low
- load_valid  in  1  cell beat valid
- load_cell  in  2  cell code: 00 open, 01 tree, 10 lumberyard, 11 stored as open
- load_ready  out  1  = (state==IDLE) && !start (combinational on start)
- start  in  1  begin run; sampled in IDLE only
- gens  in  GEN_W  number of generations; latched on accepted start
- busy  out  1  high in RUN and COUNT
- done  out  1  one-cycle pulse when results are valid
- gen_count  out  GEN_W  generations completed in the current or last run
- trees  out  W*H  tree bit per cell, index r*W+c
- lumberyards  out  W*H  lumberyard bit per cell, same indexing
- tree_count  out  CNT_W  trees counted in the final grid
- yard_count  out  CNT_W  lumberyards counted in the final grid
- resource  out  2*CNT_W  tree_count*yard_count

## Operation
- States: IDLE, RUN, COUNT, DONE.
- **Load:** in IDLE, a beat with load_valid && load_ready writes load_cell to cell load_ptr (raster order), then increments load_ptr. load_ptr wraps from W*H-1 to 0. Accepting a start resets load_ptr to 0.
- **Start:** start in IDLE latches gens, clears gen_count and the counts, and moves to RUN. If gens==0, it moves to COUNT instead. When start and load_valid are both high, start wins and no cell is written.
- **RUN:** all cells update in parallel, once per cycle. Each cell sees its 8 neighbours; neighbours off the grid count as open.
  - open becomes tree if ≥3 neighbours are trees.
  - tree becomes lumberyard if ≥3 neighbours are lumberyards.
  - lumberyard stays lumberyard if ≥1 neighbour is a lumberyard and ≥1 is a tree; otherwise it becomes open.
  - gen_count increments each RUN cycle. When gen_count reaches gens, the state goes to COUNT.
- **COUNT:** scans one row per cycle, rows 0..H-1, accumulating tree_count and yard_count. The grid is frozen. After row H-1, the state goes to DONE.
- **DONE:** registers resource = tree_count*yard_count, pulses done, and returns to IDLE.
- Outputs hold their values until the next accepted start.
- start outside IDLE is ignored. load_valid outside IDLE is ignored.
- A cell can never be both tree and lumberyard. Code 11 is never stored.

## Timing
- Reset (async assert) sets:
  - state=IDLE, grid all open (trees=0, lumberyards=0), load_ptr=0
  - busy=0, done=0, gen_count=0, tree_count=0, yard_count=0, resource=0
  - load_ready follows !start
- Reset release is synchronised by the surrounding design. The block needs no extra release logic.
- Reset mid-run aborts the run immediately. No done pulse is produced.
- Start accepted at edge T:
  - busy=1 from T.
  - First generation is visible at T+1.
  - Generation k is visible on trees/lumberyards at T+k.
- Latency from the start edge to done high is gens + H + 1 cycles:
  - gens cycles in RUN (0 if gens==0)
  - H cycles in COUNT
  - 1 cycle in DONE
- done is high for exactly one cycle. busy is low in that cycle. resource is valid in the same cycle and after.
- A new start is accepted in the cycle after done.
- A load beat is accepted the same cycle it is offered while in IDLE. Throughput is 1 cell/cycle.

## Test plan
- **Puzzle example:** load the AoC 10×10 example (W=H=10), gens=10 → tree_count=37, yard_count=31, resource=1147, gen_count=10, done at start+21.
- **gens=0:** load a 3×3 grid with 4 trees and 2 lumberyards, gens=0 → no generation, tree_count=4, yard_count=2, resource=8, done at start+4.
- **Single-rule cells:** W=H=3. Expected after 1 generation:
  - centre open with 3 tree neighbours → centre tree
  - lone lumberyard, no neighbours → open
  - lumberyard with 1 tree and 1 lumberyard neighbour → stays lumberyard
  - tree with 3 lumberyard neighbours → lumberyard
- **Load wrap and priority:** load W*H+2 cells → cells 0 and 1 overwritten by the last two beats. Assert start and load_valid together → load_ready=0, cell not written, run starts.
- **Reset mid-run:** with gens=1000, pull rst_n low at gen 5 → all outputs zero asynchronously, no done pulse, state IDLE, load_ready=1.
- **Ignored inputs while busy:** pulse start and load_valid during RUN → grid evolution and done timing are unchanged versus a clean run.
